// File: rtl/maxpool_2x2_stream.sv
// maxpool_2x2_stream: streaming 2x2/stride-2 signed max-pool over a raster IMG_W x IMG_H frame.
// Define MAXPOOL_LAST_EN to add the out_last end-of-frame marker port.
module maxpool_2x2_stream #(
  parameter int RESULT = 10,
  parameter int IMG_W  = 26,
  parameter int IMG_H  = 26
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [RESULT-1:0] d_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [RESULT-1:0] d_out,
`ifdef MAXPOOL_LAST_EN
  output logic                     out_last,
`endif
  output logic                     frame_done
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int LN = IMG_W / 2;
  localparam int LW = (LN > 1) ? $clog2(LN) : 1;

  if ((IMG_W % 2) != 0 || (IMG_H % 2) != 0) begin : g_odd
    $error("maxpool_2x2_stream: IMG_W and IMG_H must be even");
  end

  logic [CW-1:0]            r_col;
  logic [RW-1:0]            r_row;
  logic signed [RESULT-1:0] r_hold;
  logic signed [RESULT-1:0] r_lb [LN];
  logic                     r_last;
  logic                     w_acc, w_done, w_col_end;
  logic [LW-1:0]            w_idx;
  logic signed [RESULT-1:0] w_other, w_max;

  assign w_done    = r_row[0] && r_col[0];
  assign w_col_end = (r_col == CW'(IMG_W - 1));
  // only a window-completing pixel has to wait for the output register
  assign in_ready  = !(out_valid && !out_ready) || !w_done;
  assign w_acc     = in_valid && in_ready;
  assign w_idx     = LW'(r_col >> 1);
  assign w_other   = r_col[0] ? r_hold : r_lb[w_idx];
  assign w_max     = (w_other > d_in) ? w_other : d_in;
  assign frame_done = out_valid && out_ready && r_last;
`ifdef MAXPOOL_LAST_EN
  assign out_last  = out_valid && r_last;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col     <= '0;
      r_row     <= '0;
      r_hold    <= '0;
      r_last    <= 1'b0;
      out_valid <= 1'b0;
      d_out     <= '0;
    end else begin
      if (w_acc) begin
        r_col <= w_col_end ? '0 : r_col + 1'b1;
        if (w_col_end) r_row <= (r_row == RW'(IMG_H - 1)) ? '0 : r_row + 1'b1;
        if (!r_col[0]) r_hold <= r_row[0] ? w_max : d_in;
      end
      if (w_acc && w_done) begin
        d_out     <= w_max;
        out_valid <= 1'b1;
        r_last    <= w_col_end && (r_row == RW'(IMG_H - 1));
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // line buffer is always written on row-even before row-odd reads it
  always_ff @(posedge clk) begin
    if (w_acc && !r_row[0] && r_col[0]) r_lb[w_idx] <= w_max;
  end
endmodule

// File: tb/tb_maxpool_2x2_stream.sv
// tb_maxpool_2x2_stream: table-driven and randomized checks of maxpool_2x2_stream on 4x4 and 26x26 frames.
module tb_maxpool_2x2_stream;
  typedef struct {
    logic signed [9:0] d;
    logic              v;
    logic              ov;
    logic signed [9:0] dout;
    logic              fd;
  } vec_t;
  typedef struct {
    logic signed [9:0] val;
    logic              last;
  } exp_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic a_iv = 0, a_or = 0, a_ir, a_ov, a_fd;
  logic b_iv = 0, b_or = 0, b_ir, b_ov, b_fd;
  logic signed [9:0] a_d = '0, a_do, b_d = '0, b_do;
`ifdef MAXPOOL_LAST_EN
  logic a_ol, b_ol;
`endif

  always #5 clk = ~clk;

  maxpool_2x2_stream #(.RESULT(10), .IMG_W(4), .IMG_H(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(a_iv), .in_ready(a_ir), .d_in(a_d),
    .out_valid(a_ov), .out_ready(a_or), .d_out(a_do),
`ifdef MAXPOOL_LAST_EN
    .out_last(a_ol),
`endif
    .frame_done(a_fd));

  maxpool_2x2_stream #(.RESULT(10), .IMG_W(26), .IMG_H(26)) u26 (
    .clk(clk), .rst_n(rst_n), .in_valid(b_iv), .in_ready(b_ir), .d_in(b_d),
    .out_valid(b_ov), .out_ready(b_or), .d_out(b_do),
`ifdef MAXPOOL_LAST_EN
    .out_last(b_ol),
`endif
    .frame_done(b_fd));

  int checks = 0, failures = 0;
  int mn = 0, nout = 0, nfd = 0;
  logic signed [9:0] fr [0:25][0:25];
  exp_t exp_q[$];
  logic s_ir, s_ov, s_fd, s_cmp;
  logic signed [9:0] s_dv;
  logic signed [9:0] f2 [16];
  vec_t tv [33];

  task automatic chk(input string nm, input int act, input int want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d at %0t", nm, act, want, $time);
    end
  endtask

  function automatic logic signed [9:0] mx(input logic signed [9:0] x, input logic signed [9:0] y);
    return (x > y) ? x : y;
  endfunction

  // reference: store each accepted pixel at its (row,col); a window is known once its bottom-right arrives
  task automatic model_push(input int w, input int h, input logic signed [9:0] d, output logic cmp);
    int r = mn / w;
    int c = mn % w;
    fr[r][c] = d;
    cmp = (r % 2 == 1) && (c % 2 == 1);
    if (cmp) exp_q.push_back('{mx(mx(fr[r-1][c-1], fr[r-1][c]), mx(fr[r][c-1], fr[r][c])), mn == w * h - 1});
    mn = (mn + 1) % (w * h);
  endtask

  task automatic step(input bit sel, input logic v, input logic signed [9:0] d, input logic ordy);
    int w = sel ? 26 : 4;
    logic lst;
    exp_t e;
    @(negedge clk);
    if (sel) begin b_iv = v; b_d = d; b_or = ordy; end
    else begin a_iv = v; a_d = d; a_or = ordy; end
    #1;
    s_ir = sel ? b_ir : a_ir;
    s_ov = sel ? b_ov : a_ov;
    s_dv = sel ? b_do : a_do;
    s_fd = sel ? b_fd : a_fd;
`ifdef MAXPOOL_LAST_EN
    lst = sel ? b_ol : a_ol;
`else
    lst = 1'b0;
`endif
    s_cmp = 1'b0;
    if (s_fd) nfd++;
    chk("in_ready", s_ir, !(s_ov && !ordy) || !(((mn / w) % 2 == 1) && ((mn % w) % 2 == 1)));
    if (s_ov && ordy) begin
      nout++;
      if (exp_q.size() == 0) chk("unexpected_output", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("d_out", s_dv, e.val);
        chk("frame_done", s_fd, e.last);
`ifdef MAXPOOL_LAST_EN
        chk("out_last", lst, e.last);
`endif
      end
    end else chk("frame_done_idle", s_fd, 0);
    if (v && s_ir) model_push(w, sel ? 26 : 4, d, s_cmp);
  endtask

  initial begin
    logic signed [9:0] p [16];
    logic signed [9:0] cur, wmax;
    int oi [8], ov8 [8];
    int sent, cyc;
    logic rv, rr;
    f2 = '{-3, -1, 0, 0, -7, -2, 0, 0, 5, -5, -512, -512, -4, 3, -512, -512};
    oi = '{6, 8, 14, 16, 22, 24, 30, 32};
    ov8 = '{6, 8, 14, 16, -1, 0, 5, -512};
    for (int i = 0; i < 33; i++) tv[i] = '{d: (i < 16) ? 10'(i + 1) : (i < 32 ? f2[i - 16] : 10'sd0), v: i < 32, ov: 0, dout: 0, fd: 0};
    for (int k = 0; k < 8; k++) begin
      tv[oi[k]].ov = 1'b1;
      tv[oi[k]].dout = 10'(ov8[k]);
      tv[oi[k]].fd = (k == 3) || (k == 7);
    end

    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // reset mid-run with a pending output
    for (int i = 0; i < 6; i++) step(0, 1, 10'(100 + i), 0);
    step(0, 0, 0, 0);
    chk("pre_rst_ov", s_ov, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ov", a_ov, 0);
    chk("rst_dout", a_do, 0);
    chk("rst_fd", a_fd, 0);
    a_iv = 0; a_or = 0;
    @(negedge clk);
    rst_n = 1'b1;
    mn = 0;
    exp_q.delete();

    // two back-to-back 4x4 frames: ramp then signed corner windows
    nfd = 0;
    for (int i = 0; i < 33; i++) begin
      step(0, tv[i].v, tv[i].d, 1);
      chk($sformatf("tv%0d_ov", i), s_ov, tv[i].ov);
      if (tv[i].ov) chk($sformatf("tv%0d_dout", i), s_dv, tv[i].dout);
      chk($sformatf("tv%0d_fd", i), s_fd, tv[i].fd);
    end
    chk("b2b_frame_done_count", nfd, 2);

    // backpressure: only the window-completing pixel stalls
    for (int i = 0; i < 16; i++) p[i] = 10'($urandom_range(0, 1023));
    wmax = mx(mx(p[0], p[1]), mx(p[4], p[5]));
    for (int i = 0; i < 7; i++) step(0, 1, p[i], 0);
    chk("bp_noncomplete_ready", s_ir, 1);
    chk("bp_ov", s_ov, 1);
    for (int k = 0; k < 3; k++) begin
      step(0, 1, p[7], 0);
      chk("bp_stall_ready", s_ir, 0);
      chk("bp_hold_dout", s_dv, wmax);
    end
    step(0, 1, p[7], 1);
    chk("bp_release_ready", s_ir, 1);
    for (int i = 8; i < 16; i++) step(0, 1, p[i], 1);
    repeat (3) step(0, 0, 0, 1);
    chk("bp_queue_empty", exp_q.size(), 0);

    // random handshakes on two 26x26 frames
    nout = 0; nfd = 0; sent = 0; cyc = 0;
    cur = 10'($urandom_range(0, 1023));
    while (sent < 1352 && cyc < 20000) begin
      rv = 1'($urandom_range(0, 1));
      rr = 1'($urandom_range(0, 1));
      step(1, rv, cur, rr);
      if (rv && s_ir) begin
        sent++;
        cur = 10'($urandom_range(0, 1023));
      end
      cyc++;
    end
    chk("rand_sent", sent, 1352);
    while (exp_q.size() > 0 && cyc < 25000) begin
      step(1, 0, 0, 1);
      cyc++;
    end
    chk("rand_drained", exp_q.size(), 0);
    chk("rand_outputs", nout, 338);
    chk("rand_frame_done", nfd, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
